ika9958_regwr: RTL and testbench

IKA9958_REGWR -- requirements
Module: ika9958_regwr

---
 rtl/ika9958_regwr.sv | 225 ++++++++++++++++++++++
 tb/tb_ika9958_regwr.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ika9958_regwr.sv
// CPU-port register/palette/VRAM-address write decoder for a V9958-style VDP.
// Define IKA9958_REGWR_SYNC_EN to put a 2-stage synchroniser on the CPU pins.
module ika9958_regwr (
  input  logic        i_EMUCLK,
  input  logic        i_RST_n,
  input  logic        i_CS_n,
  input  logic        i_RD_n,
  input  logic        i_WR_n,
  input  logic [1:0]  i_MODE,
  input  logic [7:0]  i_DI,
  output logic        o_REG_WE,
  output logic [5:0]  o_REG_ADDR,
  output logic [7:0]  o_REG_DATA,
  output logic        o_PAL_WE,
  output logic [3:0]  o_PAL_ADDR,
  output logic [8:0]  o_PAL_DATA,
  output logic        o_VAP_WE,
  output logic [13:0] o_VAP_ADDR,
  output logic        o_VAP_WR
);

  typedef enum logic [1:0] {
    PORT_VRAM = 2'd0,
    PORT_CTRL = 2'd1,
    PORT_PAL  = 2'd2,
    PORT_IND  = 2'd3
  } port_e;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] mode;
    logic [7:0] di;
  } bus_t;

  localparam logic [5:0] REG_PAL_PTR = 6'd16;
  localparam logic [5:0] REG_IND_PTR = 6'd17;

  bus_t pin_bus;
  bus_t bus_s;

  assign pin_bus = '{cs_n: i_CS_n, rd_n: i_RD_n, wr_n: i_WR_n, mode: i_MODE, di: i_DI};

  // Reset value of all-zero decodes as "both strobes low", i.e. no operation.
`ifdef IKA9958_REGWR_SYNC_EN
  bus_t bus_meta;

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      bus_meta <= '0;
      bus_s    <= '0;
    end else begin
      bus_meta <= pin_bus;
      bus_s    <= bus_meta;
    end
  end
`else
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      bus_s <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of process ordering.
      bus_s <= pin_bus;
    end
  end
`endif

  logic  wr_act, rd_act;
  logic  wr_prev, rd_prev;
  logic  wr_stb, rd_stb;
  port_e port;

  assign wr_act = ~bus_s.cs_n & ~bus_s.wr_n &  bus_s.rd_n;
  assign rd_act = ~bus_s.cs_n & ~bus_s.rd_n &  bus_s.wr_n;
  assign wr_stb = wr_act & ~wr_prev;
  assign rd_stb = rd_act & ~rd_prev;
  assign port   = port_e'(bus_s.mode);

  // Internal state
  logic       byte_flag, byte_flag_nx;
  logic [7:0] byte0,     byte0_nx;
  logic [7:0] r17,       r17_nx;
  logic [3:0] pal_ptr,   pal_ptr_nx;
  logic       pal_flag,  pal_flag_nx;
  logic [5:0] pal_rb,    pal_rb_nx;

  // Next output values
  logic        reg_we_nx;
  logic [5:0]  reg_addr_nx;
  logic [7:0]  reg_data_nx;
  logic        pal_we_nx;
  logic [3:0]  pal_addr_nx;
  logic [8:0]  pal_data_nx;
  logic        vap_we_nx;
  logic [13:0] vap_addr_nx;
  logic        vap_wr_nx;

  // Shared register-write request from ports 1 and 3
  logic       reg_wr;
  logic [5:0] reg_wa;
  logic [7:0] reg_wd;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    byte_flag_nx = byte_flag;
    byte0_nx     = byte0;
    r17_nx       = r17;
    pal_ptr_nx   = pal_ptr;
    pal_flag_nx  = pal_flag;
    pal_rb_nx    = pal_rb;
    reg_we_nx    = 1'b0;
    reg_addr_nx  = o_REG_ADDR;
    reg_data_nx  = o_REG_DATA;
    pal_we_nx    = 1'b0;
    pal_addr_nx  = o_PAL_ADDR;
    pal_data_nx  = o_PAL_DATA;
    vap_we_nx    = 1'b0;
    vap_addr_nx  = o_VAP_ADDR;
    vap_wr_nx    = o_VAP_WR;
    reg_wr       = 1'b0;
    reg_wa       = '0;
    reg_wd       = '0;

    if (wr_stb) begin
      case (port)
        PORT_VRAM: byte_flag_nx = 1'b0;
        PORT_CTRL: begin
          if (!byte_flag) begin
            byte0_nx     = bus_s.di;
            byte_flag_nx = 1'b1;
          end else begin
            byte_flag_nx = 1'b0;
            if (bus_s.di[7]) begin
              reg_wr = 1'b1;
              reg_wa = bus_s.di[5:0];
              reg_wd = byte0;
            end else begin
              vap_we_nx   = 1'b1;
              vap_addr_nx = {bus_s.di[5:0], byte0};
              vap_wr_nx   = bus_s.di[6];
            end
          end
        end
        PORT_PAL: begin
          if (!pal_flag) begin
            pal_rb_nx   = {bus_s.di[6:4], bus_s.di[2:0]};
            pal_flag_nx = 1'b1;
          end else begin
            pal_we_nx   = 1'b1;
            pal_addr_nx = pal_ptr;
            pal_data_nx = {pal_rb, bus_s.di[2:0]};
            pal_flag_nx = 1'b0;
            pal_ptr_nx  = pal_ptr + 4'd1;
          end
        end
        PORT_IND: begin
          // Indirect writes never target R17 itself; the pointer still advances.
          if (r17[5:0] != REG_IND_PTR) begin
            reg_wr = 1'b1;
            reg_wa = r17[5:0];
            reg_wd = bus_s.di;
          end
          if (!r17[7]) r17_nx[5:0] = r17[5:0] + 6'd1;
        end
      endcase
    end

    if (rd_stb && (port == PORT_VRAM || port == PORT_CTRL)) byte_flag_nx = 1'b0;

    if (reg_wr) begin
      reg_we_nx   = 1'b1;
      reg_addr_nx = reg_wa;
      reg_data_nx = reg_wd;
      if (reg_wa == REG_PAL_PTR) begin
        pal_ptr_nx  = reg_wd[3:0];
        pal_flag_nx = 1'b0;
      end
      if (reg_wa == REG_IND_PTR) r17_nx = reg_wd;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wr_prev    <= 1'b0;
      rd_prev    <= 1'b0;
      byte_flag  <= 1'b0;
      byte0      <= '0;
      r17        <= '0;
      pal_ptr    <= '0;
      pal_flag   <= 1'b0;
      pal_rb     <= '0;
      o_REG_WE   <= 1'b0;
      o_REG_ADDR <= '0;
      o_REG_DATA <= '0;
      o_PAL_WE   <= 1'b0;
      o_PAL_ADDR <= '0;
      o_PAL_DATA <= '0;
      o_VAP_WE   <= 1'b0;
      o_VAP_ADDR <= '0;
      o_VAP_WR   <= 1'b0;
    end else begin
      wr_prev    <= wr_act;
      rd_prev    <= rd_act;
      byte_flag  <= byte_flag_nx;
      byte0      <= byte0_nx;
      r17        <= r17_nx;
      pal_ptr    <= pal_ptr_nx;
      pal_flag   <= pal_flag_nx;
      pal_rb     <= pal_rb_nx;
      o_REG_WE   <= reg_we_nx;
      o_REG_ADDR <= reg_addr_nx;
      o_REG_DATA <= reg_data_nx;
      o_PAL_WE   <= pal_we_nx;
      o_PAL_ADDR <= pal_addr_nx;
      o_PAL_DATA <= pal_data_nx;
      o_VAP_WE   <= vap_we_nx;
      o_VAP_ADDR <= vap_addr_nx;
      o_VAP_WR   <= vap_wr_nx;
    end
  end

endmodule

// File: tb/tb_ika9958_regwr.sv
// Table-driven bench for ika9958_regwr: one CPU access per row, with the
// expected output event, plus hand-written reset and latency sequences.
`timescale 1ns/1ps
module tb_ika9958_regwr;

`ifdef IKA9958_REGWR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int HOLD = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n, rd_n, wr_n;
  logic [1:0]  mode;
  logic [7:0]  di;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [8:0]  pal_data;
  logic        vap_we;
  logic [13:0] vap_addr;
  logic        vap_wr;

  ika9958_regwr dut (
    .i_EMUCLK  (clk),
    .i_RST_n   (rst_n),
    .i_CS_n    (cs_n),
    .i_RD_n    (rd_n),
    .i_WR_n    (wr_n),
    .i_MODE    (mode),
    .i_DI      (di),
    .o_REG_WE  (reg_we),
    .o_REG_ADDR(reg_addr),
    .o_REG_DATA(reg_data),
    .o_PAL_WE  (pal_we),
    .o_PAL_ADDR(pal_addr),
    .o_PAL_DATA(pal_data),
    .o_VAP_WE  (vap_we),
    .o_VAP_ADDR(vap_addr),
    .o_VAP_WR  (vap_wr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor: each one-cycle pulse is seen on exactly one falling edge.
  int          reg_cnt = 0, pal_cnt = 0, vap_cnt = 0;
  logic [5:0]  seen_reg_addr;
  logic [7:0]  seen_reg_data;
  logic [3:0]  seen_pal_addr;
  logic [8:0]  seen_pal_data;
  logic [13:0] seen_vap_addr;
  logic        seen_vap_wr;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (reg_we) begin
        reg_cnt       <= reg_cnt + 1;
        seen_reg_addr <= reg_addr;
        seen_reg_data <= reg_data;
      end
      if (pal_we) begin
        pal_cnt       <= pal_cnt + 1;
        seen_pal_addr <= pal_addr;
        seen_pal_data <= pal_data;
      end
      if (vap_we) begin
        vap_cnt       <= vap_cnt + 1;
        seen_vap_addr <= vap_addr;
        seen_vap_wr   <= vap_wr;
      end
    end
  end

  typedef enum {OP_WR, OP_RD, OP_BOTH} op_e;
  typedef enum {EV_NONE, EV_REG, EV_PAL, EV_VAP} ev_e;

  typedef struct {
    logic [1:0]  port;
    op_e         op;
    logic [7:0]  din;
    ev_e         ev;
    logic [13:0] addr;
    logic [8:0]  data;
    logic        vwr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] p, input op_e o, input logic [7:0] d,
                     input ev_e e, input logic [13:0] a, input logic [8:0] dt, input logic w);
    vec_t v;
    v.port = p; v.op = o; v.din = d; v.ev = e; v.addr = a; v.data = dt; v.vwr = w;
    vecs.push_back(v);
  endtask

  task automatic access(input logic [1:0] p, input op_e o, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0;
    mode = p;
    di   = d;
    wr_n = !(o == OP_WR || o == OP_BOTH);
    rd_n = !(o == OP_RD || o == OP_BOTH);
    repeat (HOLD) @(negedge clk);
    cs_n = 1'b1;
    wr_n = 1'b1;
    rd_n = 1'b1;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int r0, p0, a0;
    r0 = reg_cnt; p0 = pal_cnt; a0 = vap_cnt;
    access(v.port, v.op, v.din);
    check($sformatf("v%0d reg_we count", i), reg_cnt - r0, (v.ev == EV_REG) ? 1 : 0);
    check($sformatf("v%0d pal_we count", i), pal_cnt - p0, (v.ev == EV_PAL) ? 1 : 0);
    check($sformatf("v%0d vap_we count", i), vap_cnt - a0, (v.ev == EV_VAP) ? 1 : 0);
    case (v.ev)
      EV_REG: begin
        check($sformatf("v%0d reg_addr", i), seen_reg_addr, v.addr[5:0]);
        check($sformatf("v%0d reg_data", i), seen_reg_data, v.data[7:0]);
      end
      EV_PAL: begin
        check($sformatf("v%0d pal_addr", i), seen_pal_addr, v.addr[3:0]);
        check($sformatf("v%0d pal_data", i), seen_pal_data, v.data);
      end
      EV_VAP: begin
        check($sformatf("v%0d vap_addr", i), seen_vap_addr, v.addr);
        check($sformatf("v%0d vap_wr", i), seen_vap_wr, v.vwr);
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " reg_we"},   reg_we,   0);
    check({tag, " reg_addr"}, reg_addr, 0);
    check({tag, " reg_data"}, reg_data, 0);
    check({tag, " pal_we"},   pal_we,   0);
    check({tag, " pal_addr"}, pal_addr, 0);
    check({tag, " pal_data"}, pal_data, 0);
    check({tag, " vap_we"},   vap_we,   0);
    check({tag, " vap_addr"}, vap_addr, 0);
    check({tag, " vap_wr"},   vap_wr,   0);
  endtask

  initial begin
    int r0, p0, n;
    bit found;

    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; mode = 2'd0; di = 8'h00;

    // Control port: register write, VRAM address setup, flag clearing
    add(1, OP_WR,   8'h5A, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h87, EV_REG,  7, 9'h05A, 0);
    add(1, OP_WR,   8'h34, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h52, EV_VAP,  14'h1234, 0, 1);
    add(1, OP_WR,   8'h00, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h12, EV_VAP,  14'h1200, 0, 0);
    add(1, OP_WR,   8'h11, EV_NONE, 0, 0, 0);
    add(1, OP_RD,   8'h00, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h22, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h89, EV_REG,  9, 9'h022, 0);
    add(1, OP_WR,   8'h33, EV_NONE, 0, 0, 0);
    add(0, OP_WR,   8'h44, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h55, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'hC1, EV_REG,  1, 9'h055, 0);
    add(1, OP_WR,   8'h44, EV_NONE, 0, 0, 0);
    add(1, OP_BOTH, 8'h85, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h82, EV_REG,  2, 9'h044, 0);
    // Indirect port: auto-increment with wrap, AII hold, R17 suppression
    add(1, OP_WR,   8'h3E, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h91, EV_REG,  17, 9'h03E, 0);
    add(3, OP_WR,   8'hA1, EV_REG,  62, 9'h0A1, 0);
    add(3, OP_WR,   8'hA2, EV_REG,  63, 9'h0A2, 0);
    add(3, OP_WR,   8'hA3, EV_REG,  0,  9'h0A3, 0);
    add(1, OP_WR,   8'h85, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h91, EV_REG,  17, 9'h085, 0);
    add(3, OP_WR,   8'hB1, EV_REG,  5, 9'h0B1, 0);
    add(3, OP_WR,   8'hB2, EV_REG,  5, 9'h0B2, 0);
    add(3, OP_WR,   8'hB3, EV_REG,  5, 9'h0B3, 0);
    add(1, OP_WR,   8'h11, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h91, EV_REG,  17, 9'h011, 0);
    add(3, OP_WR,   8'h55, EV_NONE, 0, 0, 0);
    add(3, OP_WR,   8'h66, EV_REG,  18, 9'h066, 0);
    add(3, OP_RD,   8'h00, EV_NONE, 0, 0, 0);
    add(3, OP_WR,   8'h77, EV_REG,  19, 9'h077, 0);
    // Palette port: pointer load via R16, wrap, read ignored, flag reset
    add(1, OP_WR,   8'h0F, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h90, EV_REG,  16, 9'h00F, 0);
    add(2, OP_WR,   8'h72, EV_NONE, 0, 0, 0);
    add(2, OP_WR,   8'h05, EV_PAL,  15, 9'h1D5, 0);
    add(2, OP_WR,   8'h11, EV_NONE, 0, 0, 0);
    add(2, OP_RD,   8'h00, EV_NONE, 0, 0, 0);
    add(2, OP_WR,   8'h06, EV_PAL,  0,  9'h04E, 0);
    add(2, OP_WR,   8'h12, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h03, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h90, EV_REG,  16, 9'h003, 0);
    add(2, OP_WR,   8'h23, EV_NONE, 0, 0, 0);
    add(2, OP_WR,   8'h04, EV_PAL,  3,  9'h09C, 0);
    add(1, OP_WR,   8'h10, EV_NONE, 0, 0, 0);
    add(1, OP_WR,   8'h91, EV_REG,  17, 9'h010, 0);
    add(3, OP_WR,   8'h08, EV_REG,  16, 9'h008, 0);
    add(2, OP_WR,   8'h70, EV_NONE, 0, 0, 0);
    add(2, OP_WR,   8'h07, EV_PAL,  8,  9'h1C7, 0);
    add(3, OP_WR,   8'h99, EV_NONE, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset between halves of a pair; also leaves a palette first byte pending
    access(2, OP_WR, 8'h55);
    access(1, OP_WR, 8'h01);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("mid-reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    r0 = reg_cnt;
    access(1, OP_WR, 8'h01);
    check("post-reset first byte no output", reg_cnt - r0, 0);

    // Pin-to-pulse latency, with the strobe held well past the pulse
    @(negedge clk);
    cs_n = 1'b0; mode = 2'd1; di = 8'h80; wr_n = 1'b0; rd_n = 1'b1;
    found = 1'b0; n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (reg_we && !found) begin
        found = 1'b1;
        n = k;
      end
    end
    check("latency pulse seen", found, 1);
    check("latency cycles", n, LAT);
    check("post-reset reg_addr", reg_addr, 0);
    check("post-reset reg_data", reg_data, 8'h01);
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    check("held strobe single pulse", reg_cnt - r0, 1);

    // Indirect pointer and palette state were cleared by reset
    r0 = reg_cnt;
    access(3, OP_WR, 8'h5C);
    check("post-reset ind count", reg_cnt - r0, 1);
    check("post-reset ind addr", seen_reg_addr, 0);
    check("post-reset ind data", seen_reg_data, 8'h5C);
    p0 = pal_cnt;
    access(2, OP_WR, 8'h31);
    check("post-reset pal first byte", pal_cnt - p0, 0);
    access(2, OP_WR, 8'h02);
    check("post-reset pal count", pal_cnt - p0, 1);
    check("post-reset pal addr", seen_pal_addr, 0);
    check("post-reset pal data", seen_pal_data, 9'h0CA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
